uart_bus_ctrl: RTL and testbench
================================

Name: uart_bus_ctrl

Overview:
- Parametrised 4-register CPU-bus UART with separate TX and RX FIFOs, a programmable baud divisor, 16x-oversampled receiver, loopback, and maskable sticky interrupts.
- Sits between the 8-bit CPU bus (chip select, read and write strobes) and the serial RX/TX pins.
- Next generation of the project4 peripheral: adds depth and frame-width parameters, an RX FIFO, error flags and loopback.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of 2, 2..256.
- DBITS, 8, data bits per frame, 5..8. Bus values are zero-extended or truncated to DBITS.
- OVS, 16, oversample ticks per bit; even, >= 8.

Ports:
- CLK  input  1  system clock, rising edge
- NRST  input  1  asynchronous active-low reset
- ADDR  input  2  register select: 0 STATUS, 1 INTMASK, 2 DATA, 3 BAUD
- NCS  input  1  chip select, active low
- NO  input  1  read enable, active low
- NW  input  1  write enable, active low
- DATA  inout  8  CPU data bus
- NINT  output  1  interrupt, active low
- RX  input  1  serial receive, idle high
- TX  output  1  serial transmit, idle high

Behaviour:
- Bus drive: DATA is driven only while NCS=0 and NO=0, otherwise Z. Read data is combinational from registered state.
- Access strobes: rd = ~NCS & ~NO; wr = ~NCS & ~NW. Side effects (FIFO push/pop, W1C) fire once, on the first CLK edge of an access. Edge detection uses the registered previous strobe plus ADDR.
- STATUS read bits:
  - [0] EN, [1] LOOP (both R/W)
  - [2] TX_FULL, [3] TX_EMPTY, [4] RX_AVAIL, [5] RX_FULL
  - [6] OVR, [7] FERR: sticky; writing 1 clears. A set and a clear in the same cycle resolve to set.
- INTMASK: R/W, 8 bits. NINT = ~|(STATUS[7:3] & INTMASK[7:3]), registered.
- DATA write: pushes to TX FIFO if EN=1 and not full; otherwise dropped silently.
- DATA read: returns RX FIFO head and pops it. When empty, returns 0x00 with no pop.
- BAUD: R/W only while EN=0; writes while EN=1 are ignored.
  - Tick every BAUD+1 CLK cycles (BAUD=0 gives a tick every cycle).
  - Counter is held at 0 while EN=0.
- Frame format: 1 start bit (0), DBITS data bits LSB first, 1 stop bit (1).
- TX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - Each state lasts OVS ticks.
  - Leaves IDLE on a tick when EN=1 and the FIFO is not empty; pops the FIFO at entry to START.
  - STOP returns to IDLE, or goes straight to START if the FIFO is still not empty.
- RX input path: 2-FF synchroniser, preset to 1 on reset. When LOOP=1 the receiver input is the internal TX serial value and the TX pin is held at 1.
- RX FSM, IDLE -> START -> DATA -> STOP:
  - Falling edge in IDLE with EN=1 enters START.
  - At tick OVS/2-1: if the line is high it is a false start, return to IDLE; otherwise continue.
  - DATA bits are sampled every OVS ticks thereafter; STOP is sampled at its centre.
  - Stop=0: set FERR, discard the byte.
  - Stop=1 with FIFO full: set OVR, drop the byte.
  - Otherwise push.
  - Returns to IDLE after the stop sample.
- FIFOs: circular with a count of 0..FIFO_DEPTH. A simultaneous push and pop on the same FIFO is allowed when full or empty is not blocking.
- EN 1->0: both FSMs abort to IDLE on the next edge. TX goes to 1, FIFO contents are retained, and the partial RX byte is discarded.
- Reset (async assert, sync release):
  - All registers 0: EN=0, BAUD=0, INTMASK=0, flags 0.
  - FIFOs empty, FSMs IDLE.
  - TX=1, NINT=1, DATA=Z.

Test Plan:
1. Reset mid-frame, then read all 4 registers -> STATUS=0x08, INTMASK=0x00, DATA=0x00, BAUD=0x00, TX=1, NINT=1.
2. BAUD=3, then EN=1, write DATA 0xA5 -> TX falls 1 cycle after the next tick; start bit lasts 64 CLK; bits 1,0,1,0,0,1,0,1; stop bit high; TX_EMPTY returns to 1.
3. LOOP=1, EN=1, write 0x3C and 0xC3 -> RX_AVAIL=1 after 2 frames; DATA reads return 0x3C then 0xC3 then 0x00; TX pin stays 1 throughout.
4. Drive RX with FIFO_DEPTH+1 frames without reading -> RX_FULL=1, OVR=1, first FIFO_DEPTH bytes intact. Write STATUS bit6=1 -> OVR=0.
5. Drive RX with a frame whose stop bit is 0, INTMASK=0x80 -> FERR=1 and NINT=0 one cycle later, RX_AVAIL=0. A 3-tick low glitch causes no state change.
6. Write BAUD while EN=1 -> value unchanged. Push 3 bytes with EN=1, then clear EN mid-start-bit -> TX=1 next cycle, TX FIFO count=2.

Source files
------------

// File: rtl/uart_bus_ctrl.sv
// CPU-bus UART: four 8-bit registers, TX/RX FIFOs, programmable baud tick,
// oversampled receiver, internal loopback and maskable sticky interrupt flags.
module uart_bus_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DBITS      = 8,
  parameter int unsigned OVS        = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] addr,
  input  logic       ncs,
  input  logic       no,
  input  logic       nw,
  inout  wire  [7:0] data,
  output logic       nint,
  input  logic       rx,
  output logic       tx
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(OVS);
  localparam int unsigned BW = 3;

  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
  localparam logic [OW-1:0] OVS_MID  = OW'(OVS / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus strobes; side effects fire only on the first edge of an access
  logic       rd_c, wr_c, rd_q, wr_q;
  logic [1:0] addr_q;
  logic       rd_new_c, wr_new_c, stat_wr_c;

  assign rd_c      = ~ncs & ~no;
  assign wr_c      = ~ncs & ~nw;
  assign rd_new_c  = rd_c & (~rd_q | (addr != addr_q));
  assign wr_new_c  = wr_c & (~wr_q | (addr != addr_q));
  assign stat_wr_c = wr_new_c & (addr == A_STATUS);

  logic       en, loop, ovr, ferr;
  logic [7:0] intmask, baud;
  logic       ovr_set_c, ferr_set_c;

  logic [7:0] bcnt;
  logic       tick_c;

  // FIFO storage and bookkeeping
  logic [DBITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DBITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]    tx_cnt, rx_cnt;
  logic             tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
  logic             tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;

  assign tx_empty_c = (tx_cnt == '0);
  assign tx_full_c  = (tx_cnt == CNT_FULL);
  assign rx_empty_c = (rx_cnt == '0);
  assign rx_full_c  = (rx_cnt == CNT_FULL);
  assign tx_push_c  = wr_new_c & (addr == A_DATA) & en & ~tx_full_c;
  assign rx_pop_c   = rd_new_c & (addr == A_DATA) & ~rx_empty_c;

  // TX datapath
  state_t           tx_state, tx_state_d;
  logic [OW-1:0]    tx_ovs, tx_ovs_d;
  logic [BW-1:0]    tx_bit, tx_bit_d;
  logic [DBITS-1:0] tx_sh, tx_sh_d;
  logic             tx_ser, tx_ser_d;

  // RX datapath
  state_t           rx_state, rx_state_d;
  logic [OW-1:0]    rx_ovs, rx_ovs_d;
  logic [BW-1:0]    rx_bit, rx_bit_d;
  logic [DBITS-1:0] rx_sh, rx_sh_d;
  logic             rx_s1, rx_s2, rx_prev;
  logic             rx_mux_c;

  logic [7:0] status_c, rdata_c;

  assign status_c = {ferr, ovr, rx_full_c, ~rx_empty_c, tx_empty_c, tx_full_c, loop, en};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      en      <= 1'b0;
      loop    <= 1'b0;
      ovr     <= 1'b0;
      ferr    <= 1'b0;
      intmask <= '0;
      baud    <= '0;
      nint    <= 1'b1;
    end else begin
      rd_q   <= rd_c;
      wr_q   <= wr_c;
      addr_q <= addr;
      if (stat_wr_c) begin
        en   <= data[0];
        loop <= data[1];
      end
      if (wr_new_c && addr == A_MASK) intmask <= data;
      if (wr_new_c && addr == 2'd3 && !en) baud <= data;
      // Set beats a same-cycle write-one-to-clear
      ovr  <= ovr_set_c  | (ovr  & ~(stat_wr_c & data[6]));
      ferr <= ferr_set_c | (ferr & ~(stat_wr_c & data[7]));
      nint <= ~|(status_c[7:3] & intmask[7:3]);
    end
  end

  // Baud tick generator, parked at zero while disabled
  assign tick_c = en & (bcnt == baud);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)               bcnt <= '0;
    else if (!en || tick_c)  bcnt <= '0;
    else                     bcnt <= bcnt + 8'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push_c) tx_wp <= tx_wp + AW'(1);
      if (tx_pop_c)  tx_rp <= tx_rp + AW'(1);
      if (tx_push_c != tx_pop_c) tx_cnt <= tx_push_c ? tx_cnt + CW'(1) : tx_cnt - CW'(1);
      if (rx_push_c) rx_wp <= rx_wp + AW'(1);
      if (rx_pop_c)  rx_rp <= rx_rp + AW'(1);
      if (rx_push_c != rx_pop_c) rx_cnt <= rx_push_c ? rx_cnt + CW'(1) : rx_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem[tx_wp] <= data[DBITS-1:0];
    if (rx_push_c) rx_mem[rx_wp] <= rx_sh;
  end

  // TX state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state <= S_IDLE;
      tx_ovs   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_ser   <= 1'b1;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_ovs   <= tx_ovs_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_ser   <= tx_ser_d;
      tx       <= loop ? 1'b1 : tx_ser_d;
    end
  end

  // TX next state: FIFO pops on every entry to START
  always_comb begin
    tx_state_d = tx_state;
    tx_ovs_d   = tx_ovs;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_pop_c   = 1'b0;
    tx_ser_d   = 1'b1;
    if (!en) begin
      tx_state_d = S_IDLE;
      tx_ovs_d   = '0;
      tx_bit_d   = '0;
    end else if (tick_c) begin
      case (tx_state)
        S_IDLE: begin
          if (!tx_empty_c) begin
            tx_state_d = S_START;
            tx_ovs_d   = '0;
            tx_sh_d    = tx_mem[tx_rp];
            tx_pop_c   = 1'b1;
          end
        end
        S_START: begin
          if (tx_ovs == OVS_LAST) begin
            tx_state_d = S_DATA;
            tx_ovs_d   = '0;
            tx_bit_d   = '0;
          end else begin
            tx_ovs_d = tx_ovs + OW'(1);
          end
        end
        S_DATA: begin
          if (tx_ovs == OVS_LAST) begin
            tx_ovs_d = '0;
            tx_sh_d  = tx_sh >> 1;
            if (tx_bit == BIT_LAST) tx_state_d = S_STOP;
            else                    tx_bit_d   = tx_bit + BW'(1);
          end else begin
            tx_ovs_d = tx_ovs + OW'(1);
          end
        end
        S_STOP: begin
          if (tx_ovs == OVS_LAST) begin
            tx_ovs_d = '0;
            if (!tx_empty_c) begin
              tx_state_d = S_START;
              tx_sh_d    = tx_mem[tx_rp];
              tx_pop_c   = 1'b1;
            end else begin
              tx_state_d = S_IDLE;
            end
          end else begin
            tx_ovs_d = tx_ovs + OW'(1);
          end
        end
        default: tx_state_d = S_IDLE;
      endcase
    end
    case (tx_state_d)
      S_START: tx_ser_d = 1'b0;
      S_DATA:  tx_ser_d = tx_sh_d[0];
      default: tx_ser_d = 1'b1;
    endcase
  end

  // Receiver input: loopback taps the internal serial line ahead of the synchroniser
  assign rx_mux_c = loop ? tx_ser : rx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_ovs   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= rx_mux_c;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_d;
      rx_ovs   <= rx_ovs_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
    end
  end

  // RX next state: start qualified at mid-bit, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state;
    rx_ovs_d   = rx_ovs;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_push_c  = 1'b0;
    ferr_set_c = 1'b0;
    ovr_set_c  = 1'b0;
    if (!en) begin
      rx_state_d = S_IDLE;
      rx_ovs_d   = '0;
      rx_bit_d   = '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state_d = S_START;
            rx_ovs_d   = '0;
          end
        end
        S_START: begin
          if (tick_c) begin
            if (rx_ovs == OVS_MID) begin
              rx_ovs_d   = '0;
              rx_bit_d   = '0;
              rx_state_d = rx_s2 ? S_IDLE : S_DATA;
            end else begin
              rx_ovs_d = rx_ovs + OW'(1);
            end
          end
        end
        S_DATA: begin
          if (tick_c) begin
            if (rx_ovs == OVS_LAST) begin
              rx_ovs_d = '0;
              rx_sh_d  = {rx_s2, rx_sh[DBITS-1:1]};
              if (rx_bit == BIT_LAST) rx_state_d = S_STOP;
              else                    rx_bit_d   = rx_bit + BW'(1);
            end else begin
              rx_ovs_d = rx_ovs + OW'(1);
            end
          end
        end
        S_STOP: begin
          if (tick_c) begin
            if (rx_ovs == OVS_LAST) begin
              rx_state_d = S_IDLE;
              rx_ovs_d   = '0;
              if (!rx_s2)         ferr_set_c = 1'b1;
              else if (rx_full_c) ovr_set_c  = 1'b1;
              else                rx_push_c  = 1'b1;
            end else begin
              rx_ovs_d = rx_ovs + OW'(1);
            end
          end
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  // Read mux, driven onto the bus only during a read
  always_comb begin
    rdata_c = '0;
    case (addr)
      A_STATUS: rdata_c = status_c;
      A_MASK:   rdata_c = intmask;
      A_DATA:   rdata_c = rx_empty_c ? 8'h00 : 8'(rx_mem[rx_rp]);
      default:  rdata_c = baud;
    endcase
  end

  assign data = rd_c ? rdata_c : 'z;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: register access, TX framing, loopback,
// RX overflow, framing error with interrupt, glitch rejection and EN abort.
module tb_uart_bus_ctrl;

  logic       clk = 1'b0;
  logic       nrst, ncs, no, nw, rx;
  logic [1:0] addr;
  wire  [7:0] data;
  logic [7:0] drv_val;
  logic       drv_en;
  logic       nint, tx;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] rv;
  logic [7:0] exp_byte;
  logic [7:0] exp_q [17];
  int         cnt, low_cnt;
  logic       seen, nint_at, nint_after;

  assign data = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  uart_bus_ctrl dut (
    .clk  (clk),
    .nrst (nrst),
    .addr (addr),
    .ncs  (ncs),
    .no   (no),
    .nw   (nw),
    .data (data),
    .nint (nint),
    .rx   (rx),
    .tx   (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    ncs = 1'b1; no = 1'b1; nw = 1'b1; drv_en = 1'b0; drv_val = '0; addr = '0; rx = 1'b1;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = a; drv_val = v; drv_en = 1'b1; ncs = 1'b0; nw = 1'b0;
    @(negedge clk);
    ncs = 1'b1; nw = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a; ncs = 1'b0; no = 1'b0;
    #2 v = data;
    @(negedge clk);
    ncs = 1'b1; no = 1'b1;
  endtask

  // One frame on the RX pin at 16 clocks per bit (BAUD=0)
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Reset in the middle of a frame
    bus_write(2'd0, 8'h01);
    bus_write(2'd2, 8'h00);
    repeat (5) @(negedge clk);
    check("t1_tx_mid_frame", tx, 1'b0);
    #2 nrst = 1'b0;
    #1 check("t1_tx_async_reset", tx, 1'b1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("t1_nint", nint, 1'b1);
    bus_read(2'd0, rv); check("t1_status", rv, 8'h08);
    bus_read(2'd1, rv); check("t1_intmask", rv, 8'h00);
    bus_read(2'd2, rv); check("t1_data", rv, 8'h00);
    bus_read(2'd3, rv); check("t1_baud", rv, 8'h00);
    check("t1_tx", tx, 1'b1);

    // TX framing at BAUD=3 (64 clocks per bit)
    do_reset();
    bus_write(2'd3, 8'h03);
    bus_write(2'd0, 8'h01);
    bus_write(2'd2, 8'hA5);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 400) begin @(negedge clk); cnt++; end
    check("t2_start_seen", tx, 1'b0);
    low_cnt = 0;
    while (tx === 1'b0 && low_cnt < 200) begin @(negedge clk); low_cnt++; end
    check("t2_start_len", low_cnt, 64);
    exp_byte = 8'hA5;
    repeat (31) @(negedge clk);
    check("t2_bit0", tx, exp_byte[0]);
    for (int i = 1; i < 8; i++) begin
      repeat (64) @(negedge clk);
      check($sformatf("t2_bit%0d", i), tx, exp_byte[i]);
    end
    repeat (64) @(negedge clk);
    check("t2_stop", tx, 1'b1);
    repeat (64) @(negedge clk);
    bus_read(2'd0, rv); check("t2_status_idle", rv, 8'h09);
    bus_read(2'd3, rv); check("t2_baud_rb", rv, 8'h03);

    // Loopback of two bytes; pin stays idle
    do_reset();
    bus_write(2'd0, 8'h03);
    bus_write(2'd2, 8'h3C);
    bus_write(2'd2, 8'hC3);
    low_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("t3_tx_pin_idle", low_cnt, 0);
    bus_read(2'd0, rv); check("t3_status", rv, 8'h1B);
    bus_read(2'd2, rv); check("t3_rd0", rv, 8'h3C);
    bus_read(2'd2, rv); check("t3_rd1", rv, 8'hC3);
    bus_read(2'd2, rv); check("t3_rd_empty", rv, 8'h00);

    // RX overflow: one frame more than the FIFO holds
    do_reset();
    bus_write(2'd0, 8'h01);
    for (int i = 0; i < 17; i++) begin
      exp_q[i] = 8'(i * 37 + 5);
      send_frame(exp_q[i], 1'b1);
    end
    bus_read(2'd0, rv); check("t4_status_ovr", rv, 8'h79);
    bus_write(2'd0, 8'h41);
    bus_read(2'd0, rv); check("t4_status_clr", rv, 8'h39);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd2, rv);
      check($sformatf("t4_rd%0d", i), rv, exp_q[i]);
    end
    bus_read(2'd0, rv); check("t4_status_drained", rv, 8'h09);

    // Framing error raises the interrupt one cycle after the flag
    do_reset();
    bus_write(2'd0, 8'h01);
    bus_write(2'd1, 8'h80);
    seen = 1'b0; nint_at = 1'b0; nint_after = 1'b1;
    fork
      send_frame(8'h55, 1'b0);
      begin
        @(negedge clk);
        addr = 2'd0; ncs = 1'b0; no = 1'b0;
        cnt = 0;
        while (!seen && cnt < 400) begin
          @(negedge clk);
          cnt++;
          if (data[7] === 1'b1) seen = 1'b1;
        end
        nint_at = nint;
        @(negedge clk);
        nint_after = nint;
        ncs = 1'b1; no = 1'b1;
      end
    join
    check("t5_ferr_seen", seen, 1'b1);
    check("t5_nint_same_cycle", nint_at, 1'b1);
    check("t5_nint_next_cycle", nint_after, 1'b0);
    bus_read(2'd0, rv); check("t5_status_ferr", rv, 8'h89);
    bus_write(2'd0, 8'h81);
    @(negedge clk);
    check("t5_nint_cleared", nint, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(2'd0, rv); check("t5_status_glitch", rv, 8'h09);
    bus_read(2'd2, rv); check("t5_data_empty", rv, 8'h00);

    // BAUD locked while enabled; EN abort keeps the unsent FIFO entries
    do_reset();
    bus_write(2'd0, 8'h01);
    bus_write(2'd3, 8'h05);
    bus_read(2'd3, rv); check("t6_baud_locked", rv, 8'h00);
    bus_write(2'd2, 8'h11);
    bus_write(2'd2, 8'h22);
    bus_write(2'd2, 8'h33);
    check("t6_tx_in_start", tx, 1'b0);
    bus_write(2'd0, 8'h00);
    @(posedge clk);
    #1 check("t6_tx_abort", tx, 1'b1);
    bus_read(2'd0, rv); check("t6_status_disabled", rv, 8'h00);
    bus_write(2'd0, 8'h03);
    repeat (600) @(negedge clk);
    bus_read(2'd0, rv); check("t6_status_loop", rv, 8'h1B);
    bus_read(2'd2, rv); check("t6_rd0", rv, 8'h22);
    bus_read(2'd2, rv); check("t6_rd1", rv, 8'h33);
    bus_read(2'd2, rv); check("t6_rd_empty", rv, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
